bidirect_buffer: RTL and testbench

- Clocked bidirectional bus transceiver between two tri-state ports, a and b.
- Input en selects the transfer direction:
  - en=1: a -> b (a is an input, the block drives b).
  - en=0: b -> a (b is an input, the block drives a).
- A turnaround window, during which neither side is driven, guarantees no bus contention on direction change.
- Sits between two shared buses or pads as a contention-safe bridge.

---
 rtl/bidirect_buffer_pkg.sv | 14 +
 rtl/bidirect_turn_ctrl.sv | 74 +++++++
 rtl/bidirect_buffer.sv | 52 +++++
 tb/tb_bidirect_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bidirect_buffer_pkg.sv
// Shared types for the bidirectional bus transceiver: direction/state
// encoding and turnaround counter width.
package bidirect_buffer_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    A2B  = 2'b01,
    B2A  = 2'b10,
    TURN = 2'b11
  } dir_state_t;

  localparam int TURN_CNT_W = 4;

endpackage

// File: rtl/bidirect_turn_ctrl.sv
// Direction FSM with turnaround counter. Both buses are released for exactly
// TURNAROUND cycles on every direction change; only en at the exit edge counts.
module bidirect_turn_ctrl
  import bidirect_buffer_pkg::*;
#(
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] state,
  output logic       busy
);

  localparam logic [TURN_CNT_W-1:0] TURN_LOAD =
    (TURNAROUND > 0) ? TURN_CNT_W'(TURNAROUND - 1) : '0;

  dir_state_t             cur, nxt;
  logic [TURN_CNT_W-1:0]  cnt, cnt_nxt;
  logic                   want_a2b;

  // An unknown en must resolve to b->a, so only a clean 1 selects a->b.
  always_comb begin
    want_a2b = 1'b0;
    if (en) want_a2b = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= OFF;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    case (cur)
      OFF: nxt = want_a2b ? A2B : B2A;
      A2B: begin
        if (!want_a2b) begin
          if (TURNAROUND == 0) nxt = B2A;
          else begin
            nxt     = TURN;
            cnt_nxt = TURN_LOAD;
          end
        end
      end
      B2A: begin
        if (want_a2b) begin
          if (TURNAROUND == 0) nxt = A2B;
          else begin
            nxt     = TURN;
            cnt_nxt = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (cnt == '0) nxt = want_a2b ? A2B : B2A;
        else           cnt_nxt = cnt - 1'b1;
      end
      default: nxt = OFF;
    endcase
  end

  always_comb begin
    state = cur;
    busy  = (cur == OFF) || (cur == TURN);
  end

endmodule

// File: rtl/bidirect_buffer.sv
// Contention-safe bidirectional transceiver between tri-state buses a and b.
// Define BIDIR_REG_EN to register the driven value (one cycle of latency).
module bidirect_buffer
  import bidirect_buffer_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  inout  wire [WIDTH-1:0]  a,
  inout  wire [WIDTH-1:0]  b,
  output logic [1:0]       dir,
  output logic             busy
);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_src, b_src;

  bidirect_turn_ctrl #(.TURNAROUND(TURNAROUND)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .state (state),
    .busy  (busy)
  );

  assign dir = state;

`ifdef BIDIR_REG_EN
  logic [WIDTH-1:0] q;

  // en picks the side that will be the source after this edge, so the
  // register already holds fresh data in the first driven cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= a;
    else         q <= b;
  end

  assign a_src = q;
  assign b_src = q;
`else
  assign a_src = b;
  assign b_src = a;
`endif

  assign a = (state == B2A) ? a_src : {WIDTH{1'bz}};
  assign b = (state == A2B) ? b_src : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidirect_buffer.sv
// Bench for bidirect_buffer: three instances (TURNAROUND 0, 1, 3) on shared
// en/rst, each with its own bus pair, checked against a per-instance model.
module tb_bidirect_buffer;

  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic cur_en;

  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];
  logic         drv_a [N];
  logic         drv_b [N];

  wire [W-1:0] obs_a [N];
  wire [W-1:0] obs_b [N];
  wire [1:0]   obs_dir [N];
  wire         obs_busy [N];

  // model: 0 idle, 1 a->b, 2 b->a, 3 released for turnaround
  int           mst [N];
  int           left [N];
  logic [W-1:0] mq [N];

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gi
    wire [W-1:0] a_w, b_w;
    wire [1:0]   d_w;
    wire         bz_w;

    assign a_w = drv_a[g] ? va[g] : {W{1'bz}};
    assign b_w = drv_b[g] ? vb[g] : {W{1'bz}};

    bidirect_buffer #(
      .WIDTH      (W),
      .TURNAROUND ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (a_w),
      .b    (b_w),
      .dir  (d_w),
      .busy (bz_w)
    );

    assign obs_a[g]    = a_w;
    assign obs_b[g]    = b_w;
    assign obs_dir[g]  = d_w;
    assign obs_busy[g] = bz_w;
  end

  function automatic int ta(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic logic [W-1:0] dut_val(input int i, input logic [W-1:0] src);
`ifdef BIDIR_REG_EN
    return mq[i];
`else
    return src;
`endif
  endfunction

  function automatic logic [W-1:0] exp_a(input int i);
    return (mst[i] == 2) ? dut_val(i, vb[i]) : va[i];
  endfunction

  function automatic logic [W-1:0] exp_b(input int i);
    return (mst[i] == 1) ? dut_val(i, va[i]) : vb[i];
  endfunction

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      cmp($sformatf("%s.dir[%0d]", tag, i), W'(obs_dir[i]), W'(mst[i]));
      cmp($sformatf("%s.busy[%0d]", tag, i), W'(obs_busy[i]),
          W'((mst[i] == 0) || (mst[i] == 3)));
      cmp($sformatf("%s.a[%0d]", tag, i), obs_a[i], exp_a(i));
      cmp($sformatf("%s.b[%0d]", tag, i), obs_b[i], exp_b(i));
    end
  endtask

  // The bench owns whichever side the DUT must not drive; in idle/turnaround
  // it drives both, so any DUT drive shows up as a corrupted bus value.
  task automatic apply_drive();
    for (int i = 0; i < N; i++) begin
      drv_a[i] = (mst[i] != 2);
      drv_b[i] = (mst[i] != 1);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mst[i]  = 0;
      left[i] = 0;
      mq[i]   = '0;
    end
  endtask

  task automatic model_update();
    logic         enb;
    logic [W-1:0] src;
    int           tgt;
    enb = (en === 1'b1);
    tgt = enb ? 1 : 2;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mst[i] = 0; left[i] = 0; mq[i] = '0;
      end else begin
        src = enb ? exp_a(i) : exp_b(i);
        if (mst[i] == 0) mst[i] = tgt;
        else if (mst[i] == 3) begin
          left[i] = left[i] - 1;
          if (left[i] == 0) mst[i] = tgt;
        end else if (mst[i] != tgt) begin
          if (ta(i) == 0) mst[i] = tgt;
          else begin
            mst[i]  = 3;
            left[i] = ta(i);
          end
        end
        mq[i] = src;
      end
    end
  endtask

  task automatic step(input logic e, input string tag);
    en = e;
    @(posedge clk);
    model_update();
    #1 apply_drive();
    #2 check_all(tag);
  endtask

  task automatic put(input logic [W-1:0] pa, input logic [W-1:0] pb, input string tag);
    for (int i = 0; i < N; i++) begin
      va[i] = pa;
      vb[i] = pb;
    end
    #1 check_all(tag);
  endtask

  task automatic arst(input string tag);
    rst = 1'b1;
    model_reset();
    apply_drive();
    #1 check_all({tag, ".assert"});
    step(en, {tag, ".held"});
    rst = 1'b0;
    #1 check_all({tag, ".release"});
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
    end
    model_reset();
    apply_drive();
    #2 check_all("reset");
    step(1'b0, "reset_edge");
    rst = 1'b0;

    // first edge after reset goes straight to a->b, no turnaround
    step(1'b1, "off_to_a2b");
    put(8'hA5, 8'h11, "a2b_A5");
    put(8'h3C, 8'h22, "a2b_3C");
    for (int v = 1; v <= 3; v++) begin
      put(W'(v), 8'h00, "a2b_ramp_put");
      step(1'b1, "a2b_ramp");
    end

    // a->b to b->a: T=0 flips at once, T=1 one released cycle, T=3 three
    step(1'b0, "turn_enter");
    put(8'hF0, 8'h0F, "turn_hold");
    step(1'b0, "turn_1");
    put(8'hF0, 8'h5A, "b2a_5A");
    step(1'b0, "turn_2");
    step(1'b0, "turn_3");
    put(8'h33, 8'hC3, "b2a_all");

    // en glitches inside the turnaround must not restart it
    step(1'b1, "glitch_enter");
    step(1'b0, "glitch_0");
    step(1'b1, "glitch_1");
    step(1'b0, "glitch_exit");
    step(1'b0, "glitch_settle");

    // unknown en resolves to b->a
    step(1'bx, "en_x");
    step(1'bx, "en_x_hold");

    // async reset while b->a is active
    put(8'h81, 8'h7E, "pre_arst");
    arst("arst_b2a");
    step(1'b1, "post_arst");

    cur_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3) == 0) cur_en = ~cur_en;
      step(cur_en, "rnd_step");
      for (int i = 0; i < N; i++) begin
        va[i] = W'($urandom);
        vb[i] = W'($urandom);
      end
      #1 check_all("rnd_data");
      if ($urandom_range(40) == 0) arst("rnd_arst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
